// File: rtl/quad_uart_wb_arbiter.sv
// rtl/quad_uart_wb_arbiter.sv - round-robin arbiter sharing one Wishbone slave among four requesters
// One single-beat classic cycle per grant, with a watchdog bounding every bus cycle.
module quad_uart_wb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADR_W   = 32,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*ADR_W-1:0] req_adr_i,
  input  logic [NUM_REQ*DAT_W-1:0] req_dat_i,
  input  logic [NUM_REQ-1:0]       req_we_i,
  input  logic [NUM_REQ*4-1:0]     req_sel_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic [NUM_REQ-1:0]       err_o,
  output logic [DAT_W-1:0]         rdata_o,
  output logic [ADR_W-1:0]         wb_adr_o,
  output logic [DAT_W-1:0]         wb_dat_o,
  output logic [3:0]               wb_sel_o,
  output logic                     wb_we_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  input  logic [DAT_W-1:0]         wb_dat_i,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_e;

  state_e               state_q;
  logic [1:0]           rr_ptr_q;
  logic [1:0]           cur_q;
  logic [15:0]          cnt_q;
  logic [15:0]          cnt_d;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [NUM_REQ-1:0]   err_q;
  logic [DAT_W-1:0]     rdata_q;
  logic [ADR_W-1:0]     adr_q;
  logic [DAT_W-1:0]     dat_q;
  logic [3:0]           sel_q;
  logic                 we_q;
  logic                 cyc_q;
  logic                 win_vld_d;
  logic [1:0]           win_idx_d;
  logic [1:0]           scan_idx;
  logic [NUM_REQ-1:0]   cur_onehot;

  // Scan lowest priority (the last winner) first so the closest successor overwrites it.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = 2'd0;
    scan_idx  = 2'd0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      scan_idx = rr_ptr_q + 2'(i);
      if (req_i[scan_idx]) begin
        win_vld_d = 1'b1;
        win_idx_d = scan_idx;
      end
    end
  end

  assign cnt_d      = cnt_q + 16'd1;
  assign cur_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << cur_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= 2'd3;
      cur_q    <= 2'd0;
      cnt_q    <= 16'd0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= 4'd0;
      we_q     <= 1'b0;
      cyc_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_vld_d) begin
            adr_q   <= req_adr_i[int'(win_idx_d)*ADR_W +: ADR_W];
            dat_q   <= req_dat_i[int'(win_idx_d)*DAT_W +: DAT_W];
            sel_q   <= req_sel_i[int'(win_idx_d)*4 +: 4];
            we_q    <= req_we_i[win_idx_d];
            gnt_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_d;
            cur_q   <= win_idx_d;
            cyc_q   <= 1'b1;
            cnt_q   <= 16'd0;
            state_q <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (wb_ack_i || wb_err_i || (cnt_q == 16'(TIMEOUT - 1))) begin
            // Data is captured even on error; only a watchdog expiry forces zero.
            rdata_q  <= (wb_ack_i || wb_err_i) ? wb_dat_i : '0;
            err_q    <= (wb_ack_i && !wb_err_i) ? '0 : cur_onehot;
            done_q   <= cur_onehot;
            cyc_q    <= 1'b0;
            rr_ptr_q <= cur_q;
            state_q  <= ST_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_RESP: begin
          done_q  <= '0;
          err_q   <= '0;
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt_o    = gnt_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;

endmodule

// File: tb/tb_quad_uart_wb_arbiter.sv
// tb/tb_quad_uart_wb_arbiter.sv - directed bench for quad_uart_wb_arbiter
module tb_quad_uart_wb_arbiter;
  localparam int ADR_W = 32;
  localparam int DAT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       req = '0;
  logic [4*ADR_W-1:0] req_adr = '0;
  logic [4*DAT_W-1:0] req_dat = '0;
  logic [3:0]       req_we = '0;
  logic [15:0]      req_sel = '0;
  logic [3:0]       gnt, done, err;
  logic [DAT_W-1:0] rdata;
  logic [ADR_W-1:0] wb_adr;
  logic [DAT_W-1:0] wb_dat_o;
  logic [3:0]       wb_sel;
  logic             wb_we, wb_cyc, wb_stb;
  logic [DAT_W-1:0] wb_dat_i = 32'hDEADBEEF;
  logic             wb_ack = 1'b0;
  logic             wb_err = 1'b0;

  int checks = 0;
  int errors = 0;

  int          slave_wait = 0;
  int          slave_mode = 0;
  logic [31:0] slave_rdata = 32'h0;
  int          wcnt = 0;

  quad_uart_wb_arbiter #(.NUM_REQ(4), .ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .req_i(req), .req_adr_i(req_adr), .req_dat_i(req_dat), .req_we_i(req_we), .req_sel_i(req_sel),
    .gnt_o(gnt), .done_o(done), .err_o(err), .rdata_o(rdata),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err)
  );

  always #5 clk = ~clk;

  // Slave model: mode 0 acks, mode 1 errors, mode 2 never responds; responds after slave_wait waits.
  always @(negedge clk) begin
    if (wb_cyc && wb_stb) begin
      if (slave_mode != 2 && wcnt == slave_wait) begin
        wb_ack   = (slave_mode == 0);
        wb_err   = (slave_mode == 1);
        wb_dat_i = slave_rdata;
      end else begin
        wb_ack   = 1'b0;
        wb_err   = 1'b0;
        wb_dat_i = 32'hDEADBEEF;
        wcnt++;
      end
    end else begin
      wb_ack   = 1'b0;
      wb_err   = 1'b0;
      wb_dat_i = 32'hDEADBEEF;
      wcnt     = 0;
    end
  end

  task automatic set_req(input int n, input logic [31:0] adr, input logic [31:0] dat,
                         input logic we, input logic [3:0] sel);
    req_adr[n*ADR_W +: ADR_W] = adr;
    req_dat[n*DAT_W +: DAT_W] = dat;
    req_we[n]                 = we;
    req_sel[n*4 +: 4]         = sel;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({gnt, done, err, rdata} !== '0) begin
      errors++;
      $display("FAIL reset_status: gnt=%b done=%b err=%b rdata=%h, required all zero", gnt, done, err, rdata);
    end
    checks++;
    if ({wb_adr, wb_dat_o, wb_sel, wb_we, wb_cyc, wb_stb} !== '0) begin
      errors++;
      $display("FAIL reset_bus: adr=%h dat=%h sel=%h we=%b cyc=%b stb=%b, required all zero",
               wb_adr, wb_dat_o, wb_sel, wb_we, wb_cyc, wb_stb);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    slave_mode = 0; slave_wait = 0;
    set_req(0, 32'h0C, 32'h83, 1'b1, 4'h1);
    req = 4'b0001;
    tick();
    checks++;
    if ({wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel, gnt, done} !==
        {1'b1, 1'b1, 1'b1, 32'h0C, 32'h83, 4'h1, 4'b0001, 4'b0000}) begin
      errors++;
      $display("FAIL write_bus: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h gnt=%b done=%b, required 1 1 1 0c 83 1 0001 0000",
               wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel, gnt, done);
    end
    tick();
    checks++;
    if ({wb_cyc, wb_stb, done, err, gnt} !== {1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0001}) begin
      errors++;
      $display("FAIL write_done: cyc=%b stb=%b done=%b err=%b gnt=%b, required 0 0 0001 0000 0001",
               wb_cyc, wb_stb, done, err, gnt);
    end
    req = 4'b0000;
    tick();
    checks++;
    if ({done, gnt, wb_cyc} !== 9'b0) begin
      errors++;
      $display("FAIL write_idle: done=%b gnt=%b cyc=%b, required all zero", done, gnt, wb_cyc);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    slave_mode = 0; slave_wait = 0;
    for (int n = 0; n < 4; n++) set_req(n, 32'h100 + 32'(n * 4), 32'hA0 + 32'(n), 1'b1, 4'hF);
    req = 4'b1111;
    for (int t = 0; t < 6; t++) begin
      exp_g = 4'b0001 << (t % 4);
      tick();
      checks++;
      if ({wb_cyc, gnt, wb_adr} !== {1'b1, exp_g, 32'h100 + 32'((t % 4) * 4)}) begin
        errors++;
        $display("FAIL rr_grant%0d: cyc=%b gnt=%b adr=%h, required 1 %b %h",
                 t, wb_cyc, gnt, wb_adr, exp_g, 32'h100 + 32'((t % 4) * 4));
      end
      tick();
      checks++;
      if ({done, gnt} !== {exp_g, exp_g} || !$onehot(gnt)) begin
        errors++;
        $display("FAIL rr_done%0d: done=%b gnt=%b, required %b %b", t, done, gnt, exp_g, exp_g);
      end
      if (t == 5) req = 4'b0000;
      tick();
      checks++;
      if ({done, gnt, wb_cyc} !== 9'b0) begin
        errors++;
        $display("FAIL rr_idle%0d: done=%b gnt=%b cyc=%b, required all zero", t, done, gnt, wb_cyc);
      end
    end
  endtask

  task automatic test_read_wait();
    int cyc_cnt = 0;
    int budget = 0;
    slave_mode = 0; slave_wait = 5; slave_rdata = 32'h60;
    set_req(2, 32'h14, 32'h0, 1'b0, 4'hF);
    req = 4'b0100;
    while (done == 4'b0 && budget < 40) begin
      tick();
      budget++;
      if (wb_cyc) cyc_cnt++;
    end
    checks++;
    if ({done, err, rdata} !== {4'b0100, 4'b0000, 32'h60} || cyc_cnt != 6) begin
      errors++;
      $display("FAIL read_wait: done=%b err=%b rdata=%h cyc_cycles=%0d, required 0100 0000 00000060 6",
               done, err, rdata, cyc_cnt);
    end
    req = 4'b0000;
    tick();
    checks++;
    if ({done, gnt} !== 8'b0 || rdata !== 32'h60) begin
      errors++;
      $display("FAIL read_hold: done=%b gnt=%b rdata=%h, required 0000 0000 00000060", done, gnt, rdata);
    end
  endtask

  task automatic test_timeout();
    int cyc_cnt = 0;
    int budget = 0;
    slave_mode = 2;
    set_req(1, 32'h20, 32'h55, 1'b1, 4'h3);
    req = 4'b0010;
    while (done == 4'b0 && budget < 40) begin
      tick();
      budget++;
      if (wb_cyc) cyc_cnt++;
    end
    checks++;
    if ({done, err, rdata} !== {4'b0010, 4'b0010, 32'h0} || cyc_cnt != 8) begin
      errors++;
      $display("FAIL timeout: done=%b err=%b rdata=%h cyc_cycles=%0d, required 0010 0010 00000000 8",
               done, err, rdata, cyc_cnt);
    end
    slave_mode = 0; slave_wait = 0; slave_rdata = 32'h77;
    tick();
    tick();
    checks++;
    if ({wb_cyc, gnt} !== {1'b1, 4'b0010}) begin
      errors++;
      $display("FAIL timeout_next_bus: cyc=%b gnt=%b, required 1 0010", wb_cyc, gnt);
    end
    tick();
    checks++;
    if ({done, err, rdata} !== {4'b0010, 4'b0000, 32'h77}) begin
      errors++;
      $display("FAIL timeout_next_done: done=%b err=%b rdata=%h, required 0010 0000 00000077", done, err, rdata);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_bus_err();
    int budget = 0;
    slave_mode = 1; slave_wait = 1; slave_rdata = 32'hE5;
    set_req(3, 32'h30, 32'h0, 1'b0, 4'hF);
    set_req(0, 32'h40, 32'h0, 1'b0, 4'hF);
    set_req(1, 32'h44, 32'h0, 1'b0, 4'hF);
    set_req(2, 32'h48, 32'h0, 1'b0, 4'hF);
    req = 4'b1000;
    while (done == 4'b0 && budget < 40) begin
      tick();
      budget++;
    end
    checks++;
    if ({done, err, rdata} !== {4'b1000, 4'b1000, 32'hE5}) begin
      errors++;
      $display("FAIL bus_err: done=%b err=%b rdata=%h, required 1000 1000 000000e5", done, err, rdata);
    end
    slave_mode = 0; slave_wait = 0;
    req = 4'b1111;
    tick();
    tick();
    checks++;
    if ({wb_cyc, gnt, wb_adr} !== {1'b1, 4'b0001, 32'h40}) begin
      errors++;
      $display("FAIL err_next_grant: cyc=%b gnt=%b adr=%h, required 1 0001 00000040", wb_cyc, gnt, wb_adr);
    end
    tick();
    req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid();
    int budget = 0;
    logic seen_done = 1'b0;
    slave_mode = 0; slave_wait = 5;
    set_req(1, 32'h50, 32'h0, 1'b0, 4'hF);
    req = 4'b0010;
    while (!wb_cyc && budget < 20) begin
      tick();
      budget++;
    end
    tick();
    tick();
    checks++;
    if (wb_cyc !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: cyc=%b, required 1", wb_cyc);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wb_cyc, wb_stb, gnt} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_async: cyc=%b stb=%b gnt=%b, required 0 0 0000", wb_cyc, wb_stb, gnt);
    end
    req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done != 4'b0) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    tick();
    if (done != 4'b0) seen_done = 1'b1;
    checks++;
    if ({seen_done, wb_cyc, gnt} !== {1'b0, 1'b1, 4'b0001}) begin
      errors++;
      $display("FAIL reset_mid_after: seen_done=%b cyc=%b gnt=%b, required 0 1 0001", seen_done, wb_cyc, gnt);
    end
    req = 4'b0000;
    for (int k = 0; k < 10; k++) tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_wait();
    test_timeout();
    test_bus_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
